mips_multicycle_ctrl: RTL

Multi-cycle control unit for the next-generation MIPS core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one memory port and one ALU. Unlike the single-cycle controller, it handles a variable-latency memory through a req/ready handshake. It also supports run/halt stepping for UART-driven debug, traps illegal opcodes, and counts retired instructions. It sits between the instruction register and the multi-cycle datapath muxes.

---
 rtl/mips_mc_pkg.sv | 83 ++++++++
 rtl/mips_mc_alu_dec.sv | 60 ++++++
 rtl/mips_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// -----------------------------------------------------------------------------
// mips_mc_pkg
// Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
// opcode / Funct values, ALU operation codes and datapath mux encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type Funct values (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  // Datapath mux encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mips_mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_mc_alu_dec
// Combinational ALU decoder for the multi-cycle controller.
//   i_state         : current controller state
//   i_op, i_funct   : instruction register fields
//   o_alu_ctrl      : ALU operation for this cycle (0 where the ALU is unused)
//   o_funct_illegal : R-type opcode with a Funct the core does not implement
// -----------------------------------------------------------------------------
module mips_mc_alu_dec
  import mips_mc_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_funct,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_funct_illegal
);

  logic [3:0] w_funct_alu;
  logic       w_funct_unknown;

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_funct_alu     = ALU_ADD;
    w_funct_unknown = 1'b0;
    case (i_funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      FN_SLL:  w_funct_alu = ALU_SLL;
      FN_SRL:  w_funct_alu = ALU_SRL;
      FN_JR:   w_funct_alu = ALU_ADD;  // jr never reaches RTYPE_EX
      default: w_funct_unknown = 1'b1;
    endcase
  end

  assign o_funct_illegal = (i_op == OP_RTYPE) && w_funct_unknown;

  always_comb begin
    o_alu_ctrl = ALU_AND;
    case (i_state)
      S_FETCH, S_DECODE, S_MEMADR: o_alu_ctrl = ALU_ADD;
      S_BRANCH:                    o_alu_ctrl = ALU_SUB;
      S_RTYPE_EX:                  o_alu_ctrl = w_funct_alu;
      S_IMM_EX: begin
        case (i_op)
          OP_ANDI: o_alu_ctrl = ALU_AND;
          OP_ORI:  o_alu_ctrl = ALU_OR;
          OP_LUI:  o_alu_ctrl = ALU_LUI;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      default:                     o_alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle MIPS control FSM with a req/ready memory handshake, run/halt
// stepping, illegal-opcode trap and a retired-instruction counter.
//   clk, rst (sync, active-low)
//   Op, Funct, Zero          : instruction fields and ALU zero flag
//   mem_ready, run           : memory completion, fetch permission
//   mem_req, MemWrite, IorD  : memory port control
//   IRWrite, PCEn, PCSrc     : instruction register / PC control
//   RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, ALUControl
//   illegal_op (sticky), idle, retired
// Outputs are decoded from state; IRWrite/PCWrite in FETCH follow mem_ready.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_WIDTH       = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int ALU_CTRL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            Op,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  input  logic                  mem_ready,
  input  logic                  run,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  IorD,
  output logic                  IRWrite,
  output logic                  PCEn,
  output logic [1:0]            PCSrc,
  output logic                  RegWrite,
  output logic [1:0]            RegDst,
  output logic [1:0]            MemtoReg,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  ZeroExt,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_op,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  retired
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_fetch_pend;  // fetch request issued, not yet completed
  logic                  r_illegal;
  logic [CNT_WIDTH-1:0]  r_retired;

  logic       w_fetch_go;
  logic       w_mem_req, w_mem_write, w_iord, w_irwrite, w_pcwrite;
  logic       w_branch, w_branch_ne, w_regwrite, w_zeroext, w_idle, w_retire;
  logic [1:0] w_pcsrc, w_regdst, w_memtoreg, w_srca, w_srcb;
  logic [3:0] w_alu;
  logic       w_funct_illegal;

  mips_mc_alu_dec u_alu_dec (
    .i_state         (r_state),
    .i_op            (Op),
    .i_funct         (Funct),
    .o_alu_ctrl      (w_alu),
    .o_funct_illegal (w_funct_illegal)
  );

  // Once a fetch request is out it stays out until the memory accepts it,
  // even if run drops while waiting.
  assign w_fetch_go = run | r_fetch_pend;

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    w_pcsrc     = PCSRC_ALU;
    w_regwrite  = 1'b0;
    w_regdst    = DST_RT;
    w_memtoreg  = WB_ALUOUT;
    w_srca      = SRCA_PC;
    w_srcb      = SRCB_B;
    w_zeroext   = 1'b0;
    w_idle      = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_fetch_go) begin
          w_mem_req = 1'b1;
          w_srcb    = SRCB_FOUR;
          w_irwrite = mem_ready;
          w_pcwrite = mem_ready;
          if (mem_ready) w_next = S_DECODE;
        end else begin
          w_idle = 1'b1;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) lands in ALUOut.
        w_srcb = SRCB_IMM_SH;
        case (Op)
          OP_RTYPE: begin
            if (w_funct_illegal)     w_next = S_TRAP;
            else if (Funct == FN_JR) w_next = S_JR;
            else                     w_next = S_RTYPE_EX;
          end
          OP_LW, OP_SW:                      w_next = S_MEMADR;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  w_next = S_IMM_EX;
          OP_J:                              w_next = S_JUMP;
          OP_JAL:                            w_next = S_JAL;
          default:                           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_srca = SRCA_A;
        w_srcb = SRCB_IMM;
        w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord    = 1'b1;
        w_mem_req = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_memtoreg = WB_MEM;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_RTYPE_EX: begin
        w_srca = ((Funct == FN_SLL) || (Funct == FN_SRL)) ? SRCA_SHAMT : SRCA_A;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = DST_RD;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_srca      = SRCA_A;
        w_pcsrc     = PCSRC_ALUOUT;
        w_branch    = (Op == OP_BEQ);
        w_branch_ne = (Op == OP_BNE);
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_IMM_EX: begin
        w_srca    = SRCA_A;
        w_srcb    = SRCB_IMM;
        w_zeroext = (Op == OP_ANDI) || (Op == OP_ORI);
        w_next    = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = PCSRC_JUMP;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        w_pcsrc    = PCSRC_JUMP;
        w_pcwrite  = 1'b1;
        w_regdst   = DST_R31;
        w_memtoreg = WB_PC;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JR: begin
        w_pcsrc   = PCSRC_REGA;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP: begin
        // With halting disabled the trapped word is dropped like a NOP; the
        // PC was already advanced during its fetch.
        if (!HALT_ON_ILLEGAL) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // NOTE: reset is synchronous here (rst is only looked at on the clock edge)
  // and all state updates use non-blocking assignments so every register
  // samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_fetch_pend <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_fetch_pend <= (r_state == S_FETCH) && w_fetch_go && !mem_ready;
      if ((r_state == S_DECODE) && (w_next == S_TRAP)) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Everything is forced to 0 during a reset cycle so an aborted instruction
  // cannot write anything on its way out.
  assign mem_req    = rst & w_mem_req;
  assign MemWrite   = rst & w_mem_write;
  assign IorD       = rst & w_iord;
  assign IRWrite    = rst & w_irwrite;
  assign PCEn       = rst & (w_pcwrite | (w_branch & Zero) | (w_branch_ne & ~Zero));
  assign RegWrite   = rst & w_regwrite;
  assign PCSrc      = rst ? w_pcsrc    : 2'b00;
  assign RegDst     = rst ? w_regdst   : 2'b00;
  assign MemtoReg   = rst ? w_memtoreg : 2'b00;
  assign ALUSrcA    = rst ? w_srca     : 2'b00;
  assign ALUSrcB    = rst ? w_srcb     : 2'b00;
  assign ZeroExt    = rst & w_zeroext;
  assign ALUControl = (rst && !w_idle) ? ALU_CTRL_W'(w_alu) : '0;
  assign idle       = rst & w_idle;
  assign illegal_op = r_illegal;
  assign retired    = r_retired;

endmodule
